// File: rtl/sync_pkg.sv
// Shared definitions for the sync strobe generator: FSM encoding and period floor.
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } sync_state_e;

  localparam int unsigned MIN_PERIOD = 32'd2;

endpackage

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle strobe into a level of pulse_len cycles; a reload during
// stretching restarts the count, so pulse_len >= period gives a continuous level.
module pulse_stretch #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [LEN_W-1:0] pulse_len,
  output logic             strobe_lvl
);

  logic [LEN_W-1:0] len_cnt_r;
  logic [LEN_W-1:0] len_cnt_nxt_s;
  logic             lvl_r;

  // Next length count: clear beats load, otherwise count down to zero.
  always_comb begin
    len_cnt_nxt_s = len_cnt_r;
    if (clear) begin
      len_cnt_nxt_s = {LEN_W{1'b0}};
    end else if (load) begin
      len_cnt_nxt_s = pulse_len;
    end else if (len_cnt_r != {LEN_W{1'b0}}) begin
      len_cnt_nxt_s = len_cnt_r - LEN_W'(1);
    end else begin
      len_cnt_nxt_s = {LEN_W{1'b0}};
    end
  end

  // Counter and registered level, high in the same cycle as the loading strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_cnt_r <= {LEN_W{1'b0}};
      lvl_r     <= 1'b0;
    end else begin
      len_cnt_r <= len_cnt_nxt_s;
      lvl_r     <= (len_cnt_nxt_s != {LEN_W{1'b0}});
    end
  end

  assign strobe_lvl = lvl_r;

endmodule

// File: rtl/sync_strobe_gen.sv
// Periodic epoch strobe generator, free-running or phase-locked to ext_sync.
// Optional strobe-count lock timeout is enabled with `define SYNC_TIMEOUT_EN.
module sync_strobe_gen
  import sync_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned EPOCH_W     = 16,
  parameter int unsigned TMO_STROBES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   phase,
  input  logic [LEN_W-1:0]   pulse_len,
  input  logic               ext_sync,
  output logic               strobe,
  output logic               strobe_lvl,
  output logic [EPOCH_W-1:0] epoch,
  output logic               locked,
  output logic               sync_err
);

  sync_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [CNT_W-1:0]   period_c_s, phase_c_s, period_sh_r, phase_sh_r;
  logic [LEN_W-1:0]   len_c_s, len_sh_r;
  logic [EPOCH_W-1:0] epoch_r, epoch_nxt_s;
  logic               ext_sync_d_r, ext_rise_s, wrap_s, load_shadow_s;
  logic               strobe_r, strobe_nxt_s, locked_r, locked_nxt_s;
  logic               sync_err_r, sync_err_nxt_s;

`ifdef SYNC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_STROBES + 1);
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
`endif

  // Clamp incoming configuration; phase is judged against the clamped period.
  always_comb begin
    period_c_s = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
    phase_c_s  = (phase >= period_c_s) ? {CNT_W{1'b0}} : phase;
    len_c_s    = (pulse_len == {LEN_W{1'b0}}) ? LEN_W'(1) : pulse_len;
  end

  assign ext_rise_s = ext_sync & ~ext_sync_d_r;
  assign wrap_s     = (state_r == RUN) && (cnt_r == (period_sh_r - CNT_W'(1)));
  assign cnt_inc_s  = wrap_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));

  // Next-state, counter and status logic.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    strobe_nxt_s   = 1'b0;
    sync_err_nxt_s = 1'b0;
    locked_nxt_s   = locked_r;
    epoch_nxt_s    = epoch_r;
    load_shadow_s  = 1'b0;
`ifdef SYNC_TIMEOUT_EN
    tmo_cnt_nxt_s  = {TMO_W{1'b0}};
`endif
    if (!enable) begin
      state_nxt_s  = IDLE;
      cnt_nxt_s    = {CNT_W{1'b0}};
      locked_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          load_shadow_s = 1'b1;
          epoch_nxt_s   = {EPOCH_W{1'b0}};
          locked_nxt_s  = 1'b0;
          if (mode) begin
            state_nxt_s = ARMED;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = RUN;
            cnt_nxt_s   = phase_c_s;
          end
        end
        ARMED: begin
          if (ext_rise_s) begin
            state_nxt_s  = RUN;
            cnt_nxt_s    = phase_sh_r;
            locked_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        RUN: begin
          cnt_nxt_s = cnt_inc_s;
          if (wrap_s) begin
            strobe_nxt_s  = 1'b1;
            epoch_nxt_s   = epoch_r + EPOCH_W'(1);
            load_shadow_s = 1'b1;
          end else begin
            strobe_nxt_s  = 1'b0;
          end
          if (!mode) begin
            locked_nxt_s = 1'b0;
          end else if (ext_rise_s) begin
            // Resync load wins over the wrap for the counter value.
            cnt_nxt_s = phase_sh_r;
            if (cnt_inc_s != phase_sh_r) begin
              sync_err_nxt_s = 1'b1;
              locked_nxt_s   = 1'b0;
            end else begin
              locked_nxt_s   = 1'b1;
            end
          end else begin
`ifdef SYNC_TIMEOUT_EN
            if (wrap_s && (tmo_cnt_r < TMO_W'(TMO_STROBES))) begin
              tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
              if (tmo_cnt_r == TMO_W'(TMO_STROBES - 1)) begin
                locked_nxt_s   = 1'b0;
                sync_err_nxt_s = 1'b1;
              end else begin
                locked_nxt_s   = locked_r;
              end
            end else begin
              tmo_cnt_nxt_s = tmo_cnt_r;
              locked_nxt_s  = locked_r;
            end
`else
            locked_nxt_s = locked_r;
`endif
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counter, shadow configuration and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      period_sh_r  <= CNT_W'(MIN_PERIOD);
      phase_sh_r   <= {CNT_W{1'b0}};
      len_sh_r     <= LEN_W'(1);
      epoch_r      <= {EPOCH_W{1'b0}};
      strobe_r     <= 1'b0;
      locked_r     <= 1'b0;
      sync_err_r   <= 1'b0;
      ext_sync_d_r <= 1'b0;
`ifdef SYNC_TIMEOUT_EN
      tmo_cnt_r    <= {TMO_W{1'b0}};
`endif
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      epoch_r      <= epoch_nxt_s;
      strobe_r     <= strobe_nxt_s;
      locked_r     <= locked_nxt_s;
      sync_err_r   <= sync_err_nxt_s;
      ext_sync_d_r <= ext_sync;
`ifdef SYNC_TIMEOUT_EN
      tmo_cnt_r    <= tmo_cnt_nxt_s;
`endif
      if (load_shadow_s) begin
        period_sh_r <= period_c_s;
        phase_sh_r  <= phase_c_s;
        len_sh_r    <= len_c_s;
      end else begin
        period_sh_r <= period_sh_r;
        phase_sh_r  <= phase_sh_r;
        len_sh_r    <= len_sh_r;
      end
    end
  end

  pulse_stretch #(
    .LEN_W (LEN_W)
  ) u_pulse_stretch (
    .clk        (clk),
    .reset      (reset),
    .clear      (~enable),
    .load       (strobe_nxt_s),
    .pulse_len  (len_sh_r),
    .strobe_lvl (strobe_lvl)
  );

  assign strobe   = strobe_r;
  assign epoch    = epoch_r;
  assign locked   = locked_r;
  assign sync_err = sync_err_r;

endmodule

// File: doc/sync_strobe_gen.md
Name: sync_strobe_gen

Overview:
Programmable periodic sync-strobe generator for the imitator sync path. It produces a one-cycle epoch strobe plus a stretched level version, either free-running or phase-locked to an external sync edge. Its strobe is the input of the downstream fixed-delay alignment shift register. It also maintains an epoch counter and lock status for the register map.

Parameters:
CNT_W, 32, width of period/phase counter
LEN_W, 8, width of pulse-stretch length
EPOCH_W, 16, width of epoch counter
TMO_STROBES, 4, strobes without ext_sync before lock loss (only with SYNC_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; 0 forces IDLE
mode  in  1  0 = free-run, 1 = external-lock
period  in  CNT_W  strobe period in clk cycles; values <2 treated as 2
phase  in  CNT_W  counter load value on start/resync; values >= period treated as 0
pulse_len  in  LEN_W  strobe_lvl length in cycles; 0 treated as 1
ext_sync  in  1  external sync, already synchronised to clk; active on rising edge
strobe  out  1  one-cycle registered strobe at each period wrap
strobe_lvl  out  1  stretched strobe
epoch  out  EPOCH_W  count of strobes since start
locked  out  1  external lock status
sync_err  out  1  one-cycle pulse on misaligned ext_sync edge

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0, ext_sync edge register 0.
- Edge detect: ext_rise = ext_sync & ~ext_sync_d. ext_sync_d is registered every cycle, in all states.
- Shadow config: period/phase/pulse_len are latched on leaving IDLE and at every wrap. Mid-period changes take effect from the next period.
- IDLE: counter held at 0. enable=1, mode=0: go to RUN, cnt<=phase, epoch<=0. enable=1, mode=1: go to ARMED, epoch<=0.
- ARMED: counter held. On ext_rise: go to RUN, cnt<=phase, locked<=1.
- RUN, each edge:
  - If cnt==period-1: cnt<=0 and strobe<=1.
  - Otherwise: cnt<=cnt+1 and strobe<=0.
  - First strobe is high (period-phase) edges after entry.
- RUN with mode=1, on ext_rise:
  - cnt<=phase.
  - If the non-resync next count differs from phase: sync_err<=1 for one cycle and locked<=0.
  - Otherwise locked<=1.
  - ext_rise coincident with cnt==period-1: strobe still asserted this wrap, resync load wins for cnt.
- mode changes while in RUN: mode is sampled continuously. Mode 0 ignores ext_sync and forces locked<=0.
- enable=0 in any state: IDLE at next edge; strobe, strobe_lvl, locked, sync_err go to 0 at that edge; epoch holds its value.
- strobe_lvl:
  - Length counter loads pulse_len on strobe; strobe_lvl is high while the counter is non-zero.
  - A new strobe during stretching reloads the counter.
  - pulse_len >= period: strobe_lvl stays continuously high.
- epoch: +1 on each strobe, wraps from 2^EPOCH_W-1 to 0.
- Arithmetic: unsigned. Comparisons use the clamped shadow values.

Optional Feature:
SYNC_TIMEOUT_EN:
- Defined: in RUN with mode=1, a counter counts strobes since the last ext_rise. Reaching TMO_STROBES forces locked<=0 and pulses sync_err for one cycle; the generator keeps free-running. The counter clears on ext_rise.
- Undefined: no timeout logic; locked changes only per the base rules.

Decomposition:
- Shared package/header sync_pkg: FSM state encoding (IDLE=2'd0, ARMED=2'd1, RUN=2'd2) and the minimum-period constant 2.
- One sub-module, pulse_stretch: length counter producing strobe_lvl from strobe and pulse_len.

Test Plan:
- Free-run, period=4, phase=0, pulse_len=1: strobe at edges k+4, k+8, ...; epoch 1, 2, ...; locked=0.
- period=1, phase=5: treated as period=2, phase=0; strobe every 2 cycles.
- Lock mode, period=10, phase=3: no strobe until ext_rise. After ext_rise, strobe 7 edges later and locked=1. ext_rise again at exact alignment: no sync_err.
- Lock mode, ext_rise 2 cycles early: cnt reloads 3, sync_err one cycle, locked=0; next aligned ext_rise sets locked=1.
- pulse_len=6, period=4: strobe_lvl continuously high after first strobe. pulse_len=0: strobe_lvl matches strobe.
- Reset asserted mid-RUN with cnt=7: all outputs 0 immediately. After release with enable=1, restart from phase with epoch=0.
- SYNC_TIMEOUT_EN, TMO_STROBES=4, ext_sync stopped: locked falls and sync_err pulses at the 4th strobe.
